// File: rtl/control_entrada.sv
`default_nettype none
// ============================================================================
// Module      : control_entrada
// Description : Keypad entry sequencer that captures two operands from the
//               push register and starts and displays the arithmetic unit.
// Revision    : 1.0 - initial release
// ============================================================================
module control_entrada #(
  parameter int MAX_DIG = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tecla_valida,
  input  logic [3:0]  tecla,
  input  logic [15:0] numero,
  input  logic        listo,
  output logic        push,
  output logic [3:0]  dato,
  output logic        rst_dat,
  output logic        guardado,
  output logic [15:0] op_a,
  output logic [15:0] op_b,
  output logic        inicio,
  output logic        mostrar,
  output logic [2:0]  digitos,
  output logic [3:0]  estado
);

  typedef enum logic [3:0] {
    CAP_A  = 4'd0,
    SAVE_A = 4'd1,
    CLR_A  = 4'd2,
    CAP_B  = 4'd3,
    SAVE_B = 4'd4,
    START  = 4'd5,
    WAIT   = 4'd6,
    SHOW   = 4'd7,
    CLR    = 4'd8
  } state_t;

  localparam logic [2:0] c_max_dig   = 3'(MAX_DIG);
  localparam logic [3:0] c_key_enter = 4'hA;
  localparam logic [3:0] c_key_erase = 4'hB;
  localparam logic [3:0] c_key_clear = 4'hC;

  state_t      r_state, w_state_nx;
  logic        r_push, w_push_nx;
  logic [3:0]  r_dato, w_dato_nx;
  logic        r_rst_dat, w_rst_dat_nx;
  logic        r_guardado, w_guardado_nx;
  logic [15:0] r_op_a, w_op_a_nx;
  logic [15:0] r_op_b, w_op_b_nx;
  logic        r_inicio, w_inicio_nx;
  logic        r_mostrar, w_mostrar_nx;
  logic [2:0]  r_digitos, w_digitos_nx;
  logic        w_es_digito;

  assign w_es_digito = (tecla <= 4'd9);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= CAP_A;
      r_push     <= 1'b0;
      r_dato     <= 4'd0;
      r_rst_dat  <= 1'b0;
      r_guardado <= 1'b0;
      r_op_a     <= 16'd0;
      r_op_b     <= 16'd0;
      r_inicio   <= 1'b0;
      r_mostrar  <= 1'b0;
      r_digitos  <= 3'd0;
    end else begin
      r_state    <= w_state_nx;
      r_push     <= w_push_nx;
      r_dato     <= w_dato_nx;
      r_rst_dat  <= w_rst_dat_nx;
      r_guardado <= w_guardado_nx;
      r_op_a     <= w_op_a_nx;
      r_op_b     <= w_op_b_nx;
      r_inicio   <= w_inicio_nx;
      r_mostrar  <= w_mostrar_nx;
      r_digitos  <= w_digitos_nx;
    end
  end

  // Outputs are registered alongside the state, so each state's actions are
  // applied on the edge that enters it.
  always_comb begin
    w_state_nx    = r_state;
    w_push_nx     = 1'b0;
    w_dato_nx     = r_dato;
    w_rst_dat_nx  = 1'b0;
    w_guardado_nx = 1'b0;
    w_op_a_nx     = r_op_a;
    w_op_b_nx     = r_op_b;
    w_inicio_nx   = 1'b0;
    w_mostrar_nx  = 1'b0;
    w_digitos_nx  = r_digitos;

    case (r_state)
      CAP_A, CAP_B: begin
        if (tecla_valida) begin
          if (w_es_digito) begin
            if (r_digitos < c_max_dig) begin
              w_push_nx    = 1'b1;
              w_dato_nx    = tecla;
              w_digitos_nx = r_digitos + 3'd1;
            end
          end else if (tecla == c_key_enter) begin
            if (r_digitos != 3'd0) begin
              w_state_nx = (r_state == CAP_A) ? SAVE_A : SAVE_B;
            end
          end else if (tecla == c_key_erase) begin
            w_rst_dat_nx = 1'b1;
            w_digitos_nx = 3'd0;
          end else if (tecla == c_key_clear) begin
            w_state_nx = CLR;
          end
        end
      end
      SAVE_A: w_state_nx = CLR_A;
      CLR_A:  w_state_nx = CAP_B;
      SAVE_B: w_state_nx = START;
      START:  w_state_nx = WAIT;
      WAIT: begin
        if (tecla_valida && (tecla == c_key_clear)) begin
          w_state_nx = CLR;
        end else if (listo) begin
          w_state_nx = SHOW;
        end
      end
      SHOW: begin
        if (tecla_valida) begin
          w_state_nx = CLR;
        end
      end
      CLR:     w_state_nx = CAP_A;
      default: w_state_nx = CAP_A;
    endcase

    case (w_state_nx)
      SAVE_A: begin
        w_guardado_nx = 1'b1;
        w_op_a_nx     = numero;
      end
      CLR_A: begin
        w_rst_dat_nx = 1'b1;
        w_digitos_nx = 3'd0;
      end
      SAVE_B: begin
        w_guardado_nx = 1'b1;
        w_op_b_nx     = numero;
      end
      START: w_inicio_nx  = 1'b1;
      SHOW:  w_mostrar_nx = 1'b1;
      CLR: begin
        w_rst_dat_nx = 1'b1;
        w_op_a_nx    = 16'd0;
        w_op_b_nx    = 16'd0;
        w_digitos_nx = 3'd0;
      end
      default: ;
    endcase
  end

  assign push     = r_push;
  assign dato     = r_dato;
  assign rst_dat  = r_rst_dat;
  assign guardado = r_guardado;
  assign op_a     = r_op_a;
  assign op_b     = r_op_b;
  assign inicio   = r_inicio;
  assign mostrar  = r_mostrar;
  assign digitos  = r_digitos;
  assign estado   = r_state;

endmodule
`default_nettype wire
